// File: rtl/bios_mem_seq_if.sv
// Command, byte-stream and RAM-port signals of the boot-monitor memory sequencer.
// slave = the sequencer itself, master = decoder/UART/RAM side.
interface bios_mem_seq_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;

    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;

    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              busy;
    logic              done;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  in_data, in_valid, out_ready,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output cmd_ready, in_ready, out_data, out_valid,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output busy, done
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output in_data, in_valid, out_ready,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  cmd_ready, in_ready, out_data, out_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  busy, done
    );
endinterface

// File: rtl/bios_mem_seq.sv
// Packs UART RX bytes into 32-bit RAM writes and unpacks RAM reads onto UART TX,
// one transfer at a time, for the boot monitor's write/read commands.
module bios_mem_seq #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    bios_mem_seq_if.slave      bus
);
    typedef enum logic [2:0] {
        IDLE, WR_COLLECT, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_SEND, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [31:0]       wbuf_q, wbuf_d;
    logic [3:0]        be_q, be_d;

    logic [1:0]        lane;
    logic [ADDR_W-1:0] addr_inc, addr_prev;
    logic              last_byte;
    logic [31:0]       be_mask;

    assign lane      = addr_q[1:0];
    assign addr_inc  = addr_q + ADDR_W'(1);
    // In WR_ISSUE addr already points past the last collected byte.
    assign addr_prev = addr_q - ADDR_W'(1);
    assign last_byte = (rem_q == LEN_W'(1));
    assign be_mask   = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            wbuf_q  <= '0;
            be_q    <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wbuf_q  <= wbuf_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        wbuf_d        = wbuf_q;
        be_d          = be_q;
        bus.cmd_ready = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0;
        bus.mem_be    = 4'h0;
        bus.done      = 1'b0;
        bus.busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    addr_d = bus.cmd_addr;
                    rem_d  = bus.cmd_len;
                    be_d   = 4'h0;
                    if (bus.cmd_len == '0)  state_d = DONE;
                    else if (bus.cmd_write) state_d = WR_COLLECT;
                    else                    state_d = RD_ISSUE;
                end
            end
            WR_COLLECT: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    wbuf_d[8*lane +: 8] = bus.in_data;
                    be_d[lane]          = 1'b1;
                    addr_d              = addr_inc;
                    rem_d               = rem_q - LEN_W'(1);
                    if (lane == 2'd3 || last_byte) state_d = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {addr_prev[ADDR_W-1:2], 2'b00};
                // wbuf may still hold stale read data in lanes not written this word.
                bus.mem_wdata = wbuf_q & be_mask;
                bus.mem_be    = be_q;
                if (bus.mem_gnt) begin
                    be_d    = 4'h0;
                    state_d = (rem_q == '0) ? DONE : WR_COLLECT;
                end
            end
            RD_ISSUE: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                if (bus.mem_gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.mem_rvalid) begin
                    wbuf_d  = bus.mem_rdata;
                    state_d = RD_SEND;
                end
            end
            RD_SEND: begin
                bus.out_valid = 1'b1;
                bus.out_data  = wbuf_q[8*lane +: 8];
                if (bus.out_ready) begin
                    addr_d = addr_inc;
                    rem_d  = rem_q - LEN_W'(1);
                    if (lane == 2'd3 || last_byte) state_d = last_byte ? DONE : RD_ISSUE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bios_mem_seq.sv
// Directed scoreboard bench for bios_mem_seq: stimulus pushes expected RAM
// transactions, TX bytes and done pulses; a negedge monitor pops and compares.
module tb_bios_mem_seq;
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_t;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;

    bios_mem_seq_if bus ();

    bios_mem_seq dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    mem_t        exp_mem[$];
    logic [7:0]  exp_bytes[$];
    int          done_exp = 0;
    int          gnt_stall = 0;
    bit          auto_rvalid = 1;
    bit          en_half = 0;
    bit          tog_ready = 0;
    int          req_cycles = 0;
    int          inrdy_cycles = 0;
    int          scnt = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_addr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        case (a)
            32'h0000_01FC: return 32'h4433_2211;
            32'h0000_0200: return 32'h8877_6655;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // RAM model: programmable grant stall, read data 2 cycles after grant.
    always @(posedge clk) begin
        bit acc;
        acc = bus.mem_req && bus.mem_gnt && clk_en && !rst;
        if (rst) begin
            scnt   = 0;
            rd_cnt = 0;
        end else begin
            if (acc) scnt = 0;
            else if (bus.mem_req && clk_en) scnt++;
            if (acc && !bus.mem_we) begin
                rd_cnt  = 2;
                rd_addr = bus.mem_addr;
            end else if (rd_cnt > 0) rd_cnt--;
        end
        #1;
        bus.mem_gnt = (scnt >= gnt_stall);
        if (auto_rvalid) begin
            bus.mem_rvalid = (rd_cnt == 1);
            bus.mem_rdata  = (rd_cnt == 1) ? ram_rd(rd_addr) : 32'h0;
        end
    end

    always @(posedge clk) begin
        #1;
        clk_en        = en_half ? ~clk_en : 1'b1;
        bus.out_ready = tog_ready ? ~bus.out_ready : 1'b1;
    end

    // Monitor
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_be;
    logic        p_we;
    bit          p_hold = 0;

    always @(negedge clk) begin
        mem_t e;
        if (rst) p_hold = 0;
        else begin
            if (bus.mem_req)  req_cycles++;
            if (bus.in_ready) inrdy_cycles++;
            if (p_hold) begin
                check("stall_req",   bus.mem_req,   1);
                check("stall_addr",  bus.mem_addr,  p_addr);
                check("stall_we",    bus.mem_we,    p_we);
                check("stall_be",    bus.mem_be,    p_be);
                check("stall_wdata", bus.mem_wdata, p_wdata);
            end
            if (bus.mem_req && bus.mem_gnt && clk_en) begin
                if (exp_mem.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL mem_unexpected: got addr %h we %b, expected no request", bus.mem_addr, bus.mem_we);
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_we",   bus.mem_we,   e.we);
                    check("mem_addr", bus.mem_addr, e.addr);
                    if (e.we) begin
                        check("mem_be",    bus.mem_be,    e.be);
                        check("mem_wdata", bus.mem_wdata, e.wdata);
                    end
                end
            end
            p_hold  = bus.mem_req && !(bus.mem_gnt && clk_en);
            p_addr  = bus.mem_addr;
            p_we    = bus.mem_we;
            p_be    = bus.mem_be;
            p_wdata = bus.mem_wdata;
            if (bus.out_valid && bus.out_ready && clk_en) begin
                if (exp_bytes.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL out_unexpected: got byte %h, expected none", bus.out_data);
                end else check("out_data", bus.out_data, exp_bytes.pop_front());
            end
            if (bus.done && clk_en) begin
                tests++;
                if (done_exp == 0) begin
                    fails++;
                    $display("FAIL done_unexpected: got done=1 expected 0");
                end else done_exp--;
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_cmd(input bit we, input logic [31:0] a, input logic [15:0] l);
        int k = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = we;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        do begin @(posedge clk); k++; end while (!(bus.cmd_ready && clk_en) && k < 200);
        #1;
        bus.cmd_valid = 1'b0;
        if (k >= 200) begin tests++; fails++; $display("FAIL cmd_timeout: got no accept expected accept"); end
    endtask

    task automatic send_bytes(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            bus.in_data  = w[8*i +: 8];
            bus.in_valid = 1'b1;
            do begin @(posedge clk); k++; end while (!(bus.in_ready && clk_en) && k < 200);
            #1;
            if (k >= 200) begin tests++; fails++; $display("FAIL in_timeout: got no accept expected accept"); end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin @(posedge clk); #1; k++; end while (bus.busy && k < 500);
        if (k >= 500) begin tests++; fails++; $display("FAIL idle_timeout: got busy expected idle"); end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic end_check(input string name);
        check({name, "_mem_left"},  exp_mem.size(),   0);
        check({name, "_byte_left"}, exp_bytes.size(), 0);
        check({name, "_done_left"}, done_exp,         0);
    endtask

    task automatic check_reset_outs();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_mem_req",   bus.mem_req,   0);
        check("rst_mem_we",    bus.mem_we,    0);
        check("rst_busy",      bus.busy,      0);
        check("rst_done",      bus.done,      0);
        check("rst_mem_addr",  bus.mem_addr,  0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_be",    bus.mem_be,    0);
        check("rst_out_data",  bus.out_data,  0);
    endtask

    task automatic aligned_write(input string name);
        exp_mem.push_back('{we: 1'b1, addr: 32'h100, be: 4'hF, wdata: 32'h4433_2211});
        done_exp++;
        send_cmd(1'b1, 32'h100, 16'd4);
        send_bytes(32'h4433_2211, 4);
        wait_idle();
        end_check(name);
    endtask

    initial begin
        int rq, ir;
        rst = 1'b1; clk_en = 1'b1;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
        bus.in_data = 0; bus.in_valid = 0; bus.out_ready = 1;
        bus.mem_gnt = 1; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outs();

        aligned_write("aligned");

        // Unaligned write, grant held low 3 cycles per request
        gnt_stall = 3;
        exp_mem.push_back('{we: 1'b1, addr: 32'h100, be: 4'b1000, wdata: 32'hAA00_0000});
        exp_mem.push_back('{we: 1'b1, addr: 32'h104, be: 4'b0011, wdata: 32'h0000_CCBB});
        done_exp++;
        send_cmd(1'b1, 32'h103, 16'd3);
        send_bytes(32'h00CC_BBAA, 3);
        wait_idle();
        gnt_stall = 0;
        end_check("unaligned_wr");

        // Unaligned read with TX backpressure
        tog_ready = 1;
        exp_mem.push_back('{we: 1'b0, addr: 32'h1FC, be: 4'h0, wdata: 32'h0});
        exp_mem.push_back('{we: 1'b0, addr: 32'h200, be: 4'h0, wdata: 32'h0});
        exp_bytes.push_back(8'h33); exp_bytes.push_back(8'h44); exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'h66); exp_bytes.push_back(8'h77);
        done_exp++;
        send_cmd(1'b0, 32'h1FE, 16'd5);
        wait_idle();
        tog_ready = 0;
        end_check("unaligned_rd");

        // Zero length: done at N+1, cmd_ready back at N+2, no req/in_ready
        rq = req_cycles; ir = inrdy_cycles;
        done_exp++;
        send_cmd(1'b1, 32'h500, 16'd0);
        check("zl_done_n1",      bus.done,      1);
        check("zl_cmd_ready_n1", bus.cmd_ready, 0);
        @(posedge clk); #1;
        check("zl_done_n2",      bus.done,      0);
        check("zl_cmd_ready_n2", bus.cmd_ready, 1);
        repeat (2) begin @(posedge clk); #1; end
        check("zl_no_req",      req_cycles,   rq);
        check("zl_no_in_ready", inrdy_cycles, ir);
        end_check("zero_len");

        // Address wrap
        exp_mem.push_back('{we: 1'b1, addr: 32'hFFFF_FFFC, be: 4'b1000, wdata: 32'h5A00_0000});
        exp_mem.push_back('{we: 1'b1, addr: 32'h0000_0000, be: 4'b0001, wdata: 32'h0000_00A5});
        done_exp++;
        send_cmd(1'b1, 32'hFFFF_FFFF, 16'd2);
        send_bytes(32'h0000_A55A, 2);
        wait_idle();
        end_check("wrap");

        // Reset in RD_WAIT, then a stale rvalid
        auto_rvalid = 0;
        exp_mem.push_back('{we: 1'b0, addr: 32'h300, be: 4'h0, wdata: 32'h0});
        send_cmd(1'b0, 32'h300, 16'd4);
        @(posedge clk); #1;
        check("rw_busy",    bus.busy,    1);
        check("rw_mem_req", bus.mem_req, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        check_reset_outs();
        repeat (3) begin @(posedge clk); #1; end
        check("rst_no_out_valid", bus.out_valid, 0);
        auto_rvalid = 1;
        end_check("reset_mid");
        aligned_write("post_reset");

        // clk_en gated every other cycle
        en_half = 1;
        aligned_write("clk_en");
        en_half = 0;
        repeat (2) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bios_mem_seq.md
# bios_mem_seq

Byte-stream to RAM sequencer for the boot monitor. After the command decoder parses a `write` or `read` command (size and address), it hands the transfer to this block. For writes, the block packs payload bytes from the UART receive stream into 32-bit RAM writes with byte enables. For reads, it issues RAM reads and unpacks the returned words onto the UART transmit stream. It owns the RAM port only while a transfer is active and reports completion to the decoder.

## Interface

**Parameters**
- `ADDR_W`, default 32: byte-address width.
- `LEN_W`, default 16: transfer length width, in bytes.

**Ports** (clock and reset first)
- `clk` — in, 1: the single clock.
- `rst` — in, 1: synchronous, active-high reset.
- `clk_en` — in, 1: global step enable. All state, counters and handshakes advance only on edges where `clk_en`=1.
- `cmd_valid` — in, 1: command offered.
- `cmd_ready` — out, 1: block can accept a command. High only in IDLE.
- `cmd_write` — in, 1: 1 = write, 0 = read.
- `cmd_addr` — in, ADDR_W: start byte address. Any alignment is allowed.
- `cmd_len` — in, LEN_W: number of bytes to transfer. 0 is legal.
- `in_data` / `in_valid` / `in_ready` — in 8 / in 1 / out 1: write payload byte stream from RX.
- `out_data` / `out_valid` / `out_ready` — out 8 / out 1 / in 1: read data byte stream to TX.
- `mem_req` / `mem_gnt` — out 1 / in 1: RAM request; the request is accepted on the edge where `mem_req & mem_gnt & clk_en`.
- `mem_we` — out, 1: 1 = write request.
- `mem_addr` — out, ADDR_W: word address. Bits [1:0] are always 0.
- `mem_wdata` — out, 32: write data, little-endian; byte lane k = bits [8k+7:8k].
- `mem_be` — out, 4: write byte enables.
- `mem_rvalid` / `mem_rdata` — in 1 / in 32: read data return. Arrives 1 or more cycles after the grant. At most one read is outstanding.
- `busy` — out, 1: high in every state except IDLE.
- `done` — out, 1: single-cycle pulse when a transfer completes.

## Operation

**Reset values.** `rst` forces the FSM to IDLE and clears all counters, `wdata` and `be`. Output values after reset:
- `cmd_ready` = 1
- `in_ready`, `out_valid`, `mem_req`, `mem_we`, `busy`, `done` = 0
- `mem_addr`, `mem_wdata`, `mem_be`, `out_data` = 0

Reset mid-transfer abandons the transfer with no `done`. An in-flight `mem_rvalid` that arrives after reset is ignored.

**Registers.**
- `addr`: current byte address.
- `rem`: bytes remaining.
- `lane` = `addr[1:0]`.
- `wbuf`: 32-bit word buffer.
- `be`: accumulated byte enables.

**States.**
- **IDLE**
  - On `cmd_valid & cmd_ready`, latch `addr` and `rem`.
  - If `cmd_len`=0, go to DONE.
  - Otherwise go to WR_COLLECT if `cmd_write`=1, else RD_ISSUE.
- **WR_COLLECT**
  - `in_ready`=1.
  - On each byte accepted: write it into `wbuf` lane `lane`, set `be[lane]`, increment `addr`, decrement `rem`.
  - Go to WR_ISSUE after accepting the byte for lane 3, or the byte that makes `rem`=0.
- **WR_ISSUE**
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr` = word address of the collected bytes, `mem_wdata` = `wbuf`, `mem_be` = `be`.
  - Hold all of these stable until the grant.
  - On grant: clear `be`. Go to DONE if `rem`=0, else back to WR_COLLECT.
- **RD_ISSUE**
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr` = `{addr[ADDR_W-1:2], 2'b00}`.
  - On grant, go to RD_WAIT.
- **RD_WAIT**
  - On `mem_rvalid`, capture `mem_rdata` into `wbuf` and go to RD_SEND.
- **RD_SEND**
  - `out_valid`=1, `out_data` = `wbuf` lane `lane`.
  - On `out_valid & out_ready`: increment `addr`, decrement `rem`.
  - After sending lane 3 or the last byte: go to DONE if `rem` is now 0, else RD_ISSUE.
- **DONE**
  - Assert `done` for one cycle, then go to IDLE.

**Rules.**
- Unused lanes in `mem_wdata` are 0. `mem_be` never contains bits outside the bytes actually received.
- A write is never issued with `mem_be`=0. A read never fetches a word that contributes no bytes.
- Address increments wrap modulo 2^ADDR_W: address 0xFFFF_FFFF is followed by 0x0000_0000.
- `mem_rvalid` is ignored outside RD_WAIT.
- `cmd_*` inputs are ignored outside IDLE.

## Timing

- Command acceptance: a command accepted on edge N puts the FSM in WR_COLLECT or RD_ISSUE at N+1. With `cmd_len`=0, `done` is high in cycle N+1 and `cmd_ready` is high again at N+2.
- Write path: the byte that completes a word is accepted on edge N. `mem_req` is high from cycle N+1 and `in_ready` is 0 while in WR_ISSUE.
- Read path: `rvalid` arrives on edge N and `out_valid` is high at N+1. The next read request goes out the cycle after the last byte of the word is accepted.
- Throughput, assuming zero stalls:
  - Write: 4 payload bytes per 5 cycles.
  - Read: 4 bytes per (4 + grant latency + read latency + 1) cycles.
- Cycles with `clk_en`=0 freeze everything. Outputs hold their values, and the handshakes on those cycles do not count.

## Test plan

- **Aligned write.** Write at 0x100, len 4, bytes 11 22 33 44, `mem_gnt` tied to 1. Expect exactly one write: addr 0x100, be 1111, wdata 0x44332211. Then one `done` pulse.
- **Unaligned write with grant stall.** Write at 0x103, len 3, bytes AA BB CC; `mem_gnt` held low for 3 cycles on each request. Expect:
  - Write 1: addr 0x100, be 1000, wdata 0xAA000000.
  - Write 2: addr 0x104, be 0011, wdata 0x0000CCBB.
  - Outputs stay stable throughout each stall.
- **Unaligned read with TX backpressure.** Read at 0x1FE, len 5. RAM returns 0x44332211 for 0x1FC and 0x88776655 for 0x200, with `rvalid` 2 cycles after grant; `out_ready` toggles every cycle. Expect output bytes 33 44 55 66 77 and exactly 2 reads.
- **Zero length and wrap-around.**
  - Zero-length command: `done` pulse, no `mem_req`, no `in_ready`.
  - Write at 0xFFFFFFFF, len 2: writes to 0xFFFFFFFC be 1000, then 0x00000000 be 0001.
- **Reset mid-transfer.** Assert `rst` in RD_WAIT, then fire a stale `mem_rvalid`. Expect all outputs back at reset values, no `out_valid`, no `done`, and a following aligned write completes normally.
- **`clk_en` gating.** Run the aligned write with `clk_en` high every other cycle. Expect the same memory transaction as the aligned-write test and no double-counted bytes.
